// File: rtl/parking_lot_pkg.sv
// Shared widths, task opcodes and FIFO entry layout for the parking request front end.
package parking_lot_pkg;

   localparam int PLATE_W    = 16;
   localparam int FLOOR_W    = 3;
   localparam int NUM_FLOORS = 7;

   typedef enum logic [1:0] {
      TASK_NONE = 2'd0,
      TASK_IN   = 2'd1,
      TASK_OUT  = 2'd2,
      TASK_LEAK = 2'd3
   } task_op_e;

   typedef struct packed {
      logic               is_out;
      logic [PLATE_W-1:0] plate;
   } fifo_entry_t;

   // Floors are 1-based: bit i of the bitmap stands for floor i+1. Returns 0 when nothing is set.
   function automatic logic [FLOOR_W-1:0] lowest_floor(input logic [NUM_FLOORS-1:0] bits);
      logic [FLOOR_W-1:0] f;
      f = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (bits[i]) f = FLOOR_W'(i + 1);
      end
      return f;
   endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// Arrival-ordered store of park/retrieve requests; full/empty derive from the occupancy count only.
module parking_req_fifo
   import parking_lot_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  fifo_entry_t   data_i,
   input  logic          pop_i,
   output fifo_entry_t   data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/parking_request_queue.sv
// Request front end: edge-detects user strobes, keeps a leak bitmap ahead of an in/out FIFO,
// and presents one pending task at a time to the elevator controller.
module parking_request_queue
   import parking_lot_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [PLATE_W-1:0] license_plate,
   input  logic               in_mode,
   input  logic               out_mode,
   input  logic               leakage,
   input  logic [FLOOR_W-1:0] leakage_floor,
   input  logic               todo_pop,
   output logic               todo_exists,
   output logic               todo_in,
   output logic               todo_out,
   output logic               todo_leak_move,
   output logic [PLATE_W-1:0] todo_license_plate,
   output logic [FLOOR_W-1:0] todo_leak_floor,
   output logic [FLOOR_W-1:0] queue_count,
   output logic               overflow,
   output logic               req_error
);

   localparam int CW = $clog2(DEPTH + 1);

   logic                  in_hist_q, out_hist_q, leak_hist_q;
   logic [NUM_FLOORS-1:0] leak_q, leak_d;
   logic                  overflow_q, overflow_d;
   logic                  req_error_q, req_error_d;

   logic                  in_edge, out_edge, leak_edge;
   logic                  push_req, leak_valid, leak_pending;
   logic                  pop_leak, pop_fifo;
   logic [FLOOR_W-1:0]    head_floor;
   logic [NUM_FLOORS-1:0] clr_mask, set_mask;
   task_op_e              cur_op;

   fifo_entry_t           push_entry, head_entry;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;

   assign in_edge   = in_mode & ~in_hist_q;
   assign out_edge  = out_mode & ~out_hist_q;
   assign leak_edge = leakage & ~leak_hist_q;

   always_comb begin
      push_req     = (in_edge | out_edge) & (|license_plate);
      leak_valid   = leak_edge & (|leakage_floor);
      // A simultaneous in+out keeps the retrieve and reports the dropped park.
      req_error_d  = (in_edge & out_edge)
                   | ((in_edge | out_edge) & ~(|license_plate))
                   | (leak_edge & ~(|leakage_floor));
      push_entry   = '{is_out: out_edge, plate: license_plate};

      leak_pending = |leak_q;
      head_floor   = lowest_floor(leak_q);
      pop_leak     = todo_pop & leak_pending;
      pop_fifo     = todo_pop & ~leak_pending & ~fifo_empty;
      overflow_d   = push_req & fifo_full & ~pop_fifo;

      clr_mask = '0;
      set_mask = '0;
      if (pop_leak)   clr_mask = NUM_FLOORS'(1) << (head_floor - FLOOR_W'(1));
      if (leak_valid) set_mask = NUM_FLOORS'(1) << (leakage_floor - FLOOR_W'(1));
      leak_d = (leak_q & ~clr_mask) | set_mask;
   end

   parking_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clock),
      .rst_n   (reset),
      .push_i  (push_req),
      .data_i  (push_entry),
      .pop_i   (pop_fifo),
      .data_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      cur_op = TASK_NONE;
      if (leak_pending)     cur_op = TASK_LEAK;
      else if (!fifo_empty) cur_op = head_entry.is_out ? TASK_OUT : TASK_IN;

      todo_in            = (cur_op == TASK_IN);
      todo_out           = (cur_op == TASK_OUT);
      todo_leak_move     = (cur_op == TASK_LEAK);
      todo_exists        = todo_in | todo_out | todo_leak_move;
      todo_license_plate = (todo_in | todo_out) ? head_entry.plate : '0;
      todo_leak_floor    = todo_leak_move ? head_floor : '0;
   end

   assign queue_count = FLOOR_W'(fifo_count);
   assign overflow    = overflow_q;
   assign req_error   = req_error_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_hist_q   <= 1'b0;
         out_hist_q  <= 1'b0;
         leak_hist_q <= 1'b0;
         leak_q      <= '0;
         overflow_q  <= 1'b0;
         req_error_q <= 1'b0;
      end else begin
         in_hist_q   <= in_mode;
         out_hist_q  <= out_mode;
         leak_hist_q <= leakage;
         leak_q      <= leak_d;
         overflow_q  <= overflow_d;
         req_error_q <= req_error_d;
      end
   end

endmodule

// File: tb/tb_parking_request_queue.sv
// Scoreboard bench for parking_request_queue: stimulus queues expected retired tasks and
// state snapshots; a negedge monitor compares them against what the DUT presents.
module tb_parking_request_queue;
   import parking_lot_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] license_plate = '0;
   logic        in_mode = 1'b0, out_mode = 1'b0, leakage = 1'b0, todo_pop = 1'b0;
   logic [2:0]  leakage_floor = '0;
   logic        todo_exists, todo_in, todo_out, todo_leak_move, overflow, req_error;
   logic [15:0] todo_license_plate;
   logic [2:0]  todo_leak_floor, queue_count;

   always #5 clock = ~clock;

   parking_request_queue #(.DEPTH(4)) dut (
      .clock              (clock),
      .reset              (reset),
      .license_plate      (license_plate),
      .in_mode            (in_mode),
      .out_mode           (out_mode),
      .leakage            (leakage),
      .leakage_floor      (leakage_floor),
      .todo_pop           (todo_pop),
      .todo_exists        (todo_exists),
      .todo_in            (todo_in),
      .todo_out           (todo_out),
      .todo_leak_move     (todo_leak_move),
      .todo_license_plate (todo_license_plate),
      .todo_leak_floor    (todo_leak_floor),
      .queue_count        (queue_count),
      .overflow           (overflow),
      .req_error          (req_error)
   );

   typedef struct {
      task_op_e    op;
      logic [15:0] plate;
      logic [2:0]  floor;
   } exp_task_t;

   typedef struct {
      string       nm;
      logic [3:0]  fl;   // {exists, in, out, leak}
      logic [15:0] pl;
      logic [2:0]  fc;
      logic [2:0]  cnt;
      int          ov;
      int          err;
   } snap_t;

   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_IN   = 4'b1100;
   localparam logic [3:0] F_OUT  = 4'b1010;
   localparam logic [3:0] F_LEAK = 4'b1001;

   exp_task_t exp_q[$];
   snap_t     snap_q[$];
   int checks = 0, failures = 0;
   int ov_seen = 0, err_seen = 0, exp_ov = 0, exp_err = 0;
   bit fin_req = 0, fin_done = 0;

   // Monitor: pulse counting, retired-task scoreboard, state snapshots, final drain checks.
   initial begin
      exp_task_t   e;
      snap_t       s;
      task_op_e    op_act;
      logic [20:0] t_act, t_exp;
      logic [27:0] s_act, s_exp;
      forever begin
         @(negedge clock);
         if (overflow)  ov_seen++;
         if (req_error) err_seen++;
         if (todo_pop && todo_exists) begin
            op_act = todo_leak_move ? TASK_LEAK : todo_out ? TASK_OUT : todo_in ? TASK_IN : TASK_NONE;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pop got op=%0d plate=%h floor=%0d required=none",
                        op_act, todo_license_plate, todo_leak_floor);
            end else begin
               e = exp_q.pop_front();
               t_act = {op_act, todo_license_plate, todo_leak_floor};
               t_exp = {e.op, e.plate, e.floor};
               if (t_act !== t_exp) begin
                  failures++;
                  $display("FAIL popped_task got op=%0d plate=%h floor=%0d required op=%0d plate=%h floor=%0d",
                           op_act, todo_license_plate, todo_leak_floor, e.op, e.plate, e.floor);
               end
            end
         end
         if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            s_act = {todo_exists, todo_in, todo_out, todo_leak_move, todo_license_plate,
                     todo_leak_floor, queue_count, overflow, req_error};
            s_exp = {s.fl, s.pl, s.fc, s.cnt, 2'b00};
            checks++;
            if (s_act !== s_exp) begin
               failures++;
               $display("FAIL state_%s got=%h required=%h", s.nm, s_act, s_exp);
            end
            checks++;
            if (ov_seen != s.ov) begin
               failures++;
               $display("FAIL overflow_pulses_%s got=%0d required=%0d", s.nm, ov_seen, s.ov);
            end
            checks++;
            if (err_seen != s.err) begin
               failures++;
               $display("FAIL req_error_pulses_%s got=%0d required=%0d", s.nm, err_seen, s.err);
            end
         end
         if (fin_req && !fin_done) begin
            checks++;
            if (exp_q.size() != 0) begin
               failures++;
               $display("FAIL tasks_not_retired got=%0d required=0", exp_q.size());
            end
            fin_done = 1;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_state(input string nm, input logic [3:0] fl, input logic [15:0] pl,
                               input logic [2:0] fc, input logic [2:0] cnt);
      snap_t s;
      s.nm = nm; s.fl = fl; s.pl = pl; s.fc = fc; s.cnt = cnt; s.ov = exp_ov; s.err = exp_err;
      snap_q.push_back(s);
   endtask

   task automatic exp_task(input task_op_e op, input logic [15:0] pl, input logic [2:0] fc);
      exp_task_t e;
      e.op = op; e.plate = pl; e.floor = fc;
      exp_q.push_back(e);
   endtask

   task automatic req(input logic im, input logic om, input logic [15:0] pl);
      in_mode = im; out_mode = om; license_plate = pl;
      step();
      in_mode = 1'b0; out_mode = 1'b0; license_plate = '0;
      step();
   endtask

   task automatic leak(input logic [2:0] f);
      leakage = 1'b1; leakage_floor = f;
      step();
      leakage = 1'b0; leakage_floor = '0;
      step();
   endtask

   task automatic pop();
      todo_pop = 1'b1;
      step();
      todo_pop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] plates2 [5];
      plates2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

      repeat (3) step();
      expect_state("in_reset", F_NONE, '0, '0, 3'd0);
      reset = 1'b1;
      step();

      // single park request, one-cycle latency, then retire
      req(1'b1, 1'b0, 16'h9423);
      expect_state("t1_present", F_IN, 16'h9423, '0, 3'd1);
      exp_task(TASK_IN, 16'h9423, '0);
      pop();
      expect_state("t1_empty", F_NONE, '0, '0, 3'd0);

      // fill past depth: fifth request overflows
      for (int i = 0; i < 5; i++) begin
         if (i == 4) exp_ov++;
         req(1'b1, 1'b0, plates2[i]);
      end
      expect_state("t2_full", F_IN, 16'h1111, '0, 3'd4);
      for (int i = 0; i < 4; i++) exp_task(TASK_IN, plates2[i], '0);
      repeat (4) pop();
      expect_state("t2_drained", F_NONE, '0, '0, 3'd0);

      // leaks pre-empt queued retrieve, lowest floor first
      req(1'b0, 1'b1, 16'h8754);
      leak(3'd3);
      leak(3'd1);
      expect_state("t3_leak1", F_LEAK, '0, 3'd1, 3'd1);
      exp_task(TASK_LEAK, '0, 3'd1);
      exp_task(TASK_LEAK, '0, 3'd3);
      exp_task(TASK_OUT, 16'h8754, '0);
      pop();
      expect_state("t3_leak3", F_LEAK, '0, 3'd3, 3'd1);
      pop();
      expect_state("t3_out", F_OUT, 16'h8754, '0, 3'd1);
      pop();
      expect_state("t3_empty", F_NONE, '0, '0, 3'd0);

      // conflicting and invalid requests
      exp_err++;
      req(1'b1, 1'b1, 16'h5755);
      expect_state("t4_conflict", F_OUT, 16'h5755, '0, 3'd1);
      exp_err++;
      req(1'b1, 1'b0, 16'h0000);
      expect_state("t4_zero_plate", F_OUT, 16'h5755, '0, 3'd1);
      exp_err++;
      leak(3'd0);
      expect_state("t4_zero_floor", F_OUT, 16'h5755, '0, 3'd1);
      exp_task(TASK_OUT, 16'h5755, '0);
      pop();
      pop();  // nothing presented: ignored
      expect_state("t4_empty", F_NONE, '0, '0, 3'd0);

      // held strobe counts once; full + pop + push in one cycle
      in_mode = 1'b1; license_plate = 16'h3851;
      repeat (3) step();
      in_mode = 1'b0; license_plate = '0;
      step();
      expect_state("t5_held", F_IN, 16'h3851, '0, 3'd1);
      req(1'b1, 1'b0, 16'h1001);
      req(1'b1, 1'b0, 16'h1002);
      req(1'b1, 1'b0, 16'h1003);
      exp_task(TASK_IN, 16'h3851, '0);
      in_mode = 1'b1; license_plate = 16'h6666; todo_pop = 1'b1;
      step();
      in_mode = 1'b0; license_plate = '0; todo_pop = 1'b0;
      step();
      expect_state("t5_pop_push", F_IN, 16'h1001, '0, 3'd4);
      exp_task(TASK_IN, 16'h1001, '0);
      exp_task(TASK_IN, 16'h1002, '0);
      exp_task(TASK_IN, 16'h1003, '0);
      exp_task(TASK_IN, 16'h6666, '0);
      repeat (4) pop();
      expect_state("t5_empty", F_NONE, '0, '0, 3'd0);

      // pop of leak floor 2 with a fresh edge for floor 2 keeps it pending
      leak(3'd2);
      expect_state("t7_leak2", F_LEAK, '0, 3'd2, 3'd0);
      exp_task(TASK_LEAK, '0, 3'd2);
      leakage = 1'b1; leakage_floor = 3'd2; todo_pop = 1'b1;
      step();
      leakage = 1'b0; leakage_floor = '0; todo_pop = 1'b0;
      step();
      expect_state("t7_still2", F_LEAK, '0, 3'd2, 3'd0);
      exp_task(TASK_LEAK, '0, 3'd2);
      pop();
      expect_state("t7_empty", F_NONE, '0, '0, 3'd0);

      // new leak while a park is presented; same-cycle pop retires the park
      req(1'b1, 1'b0, 16'h7777);
      req(1'b1, 1'b0, 16'h7778);
      exp_task(TASK_IN, 16'h7777, '0);
      leakage = 1'b1; leakage_floor = 3'd4; todo_pop = 1'b1;
      step();
      leakage = 1'b0; leakage_floor = '0; todo_pop = 1'b0;
      step();
      expect_state("t8_leak4", F_LEAK, '0, 3'd4, 3'd1);
      exp_task(TASK_LEAK, '0, 3'd4);
      exp_task(TASK_IN, 16'h7778, '0);
      pop();
      pop();
      expect_state("t8_empty", F_NONE, '0, '0, 3'd0);

      // asynchronous reset mid-operation
      req(1'b1, 1'b0, 16'h1201);
      req(1'b0, 1'b1, 16'h1202);
      req(1'b1, 1'b0, 16'h1203);
      leak(3'd2);
      leak(3'd5);
      expect_state("t6_loaded", F_LEAK, '0, 3'd2, 3'd3);
      step();
      #1;
      reset = 1'b0;
      expect_state("t6_reset_now", F_NONE, '0, '0, 3'd0);
      step();
      step();
      reset = 1'b1;
      step();
      step();
      expect_state("t6_released", F_NONE, '0, '0, 3'd0);
      step();

      fin_req = 1;
      for (int i = 0; i < 10 && !fin_done; i++) step();
      if (!fin_done) begin
         $display("FAIL monitor_final_check not reached");
         $fatal(1, "monitor stalled");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
